piso_stream_serializer: RTL and testbench
=========================================

PISO_STREAM_SERIALIZER -- requirements
Module: piso_stream_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: parallel word width in bits.
REQ-002 SHALL have parameter LANES, default 1: bits per serial beat; DATA_WIDTH % LANES == 0, else elaboration error.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = bit 0 first (lane i = word bit k*LANES+i); 1 = top LANES bits first.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port din  input  DATA_WIDTH  parallel word.
REQ-007 SHALL have port din_valid  input  1  din holds a word.
REQ-008 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-009 SHALL have port dout  output  LANES  current serial beat.
REQ-010 SHALL have port dout_valid  output  1  dout holds a beat.
REQ-011 SHALL have port dout_ready  input  1  sink consumes the beat.
REQ-012 SHALL have port dout_last  output  1  final beat of the current word.
REQ-013 SHALL have port busy  output  1  a word is in flight (state != IDLE).

Function
REQ-014 SHALL define BEATS = DATA_WIDTH/LANES and use a beat counter of width $clog2(BEATS+1).
REQ-015 SHALL implement states IDLE, SHIFT, and PARITY (PARITY only when the feature is compiled in).
REQ-016 SHALL accept a word on din_valid & din_ready; a handshake occurs on that edge.
REQ-017 SHALL drive din_ready = 1 in IDLE, or in the final beat while dout_ready = 1; otherwise 0.
REQ-018 SHALL present the first beat with dout_valid = 1 in the cycle after acceptance (1-cycle latency).
REQ-019 SHALL hold dout, dout_last and dout_valid stable while dout_valid & ~dout_ready (back-pressure).
REQ-020 SHALL advance one beat per cycle with dout_valid & dout_ready, in the MSB_FIRST-selected order.
REQ-021 SHALL assert dout_last on beat BEATS-1 only (or on the parity beat when enabled).
REQ-022 SHALL, on last-beat handshake with a new word accepted the same edge, stay in SHIFT with no bubble; otherwise go to IDLE.
REQ-023 SHALL drive dout = 0 whenever dout_valid = 0.
REQ-024 SHALL, for LANES == DATA_WIDTH, emit the word as one beat with dout_last = 1.

Reset
REQ-025 SHALL, while reset = 1, force state IDLE, counter 0, shift register 0, dout 0, dout_valid 0, dout_last 0, busy 0, din_ready 0.
REQ-026 SHALL, on reset mid-word, discard the remaining beats immediately; the next word starts from beat 0.
REQ-027 SHALL drive din_ready = 1 from the first clk edge after reset is released.

Configuration
REQ-028 SHALL, with PISO_PARITY_EN defined, append one beat after the data beats: lane 0 = even parity (XOR) of the word, other lanes 0; this beat carries dout_last.
REQ-029 SHALL, without PISO_PARITY_EN, emit exactly BEATS beats per word with no PARITY state or parity logic.

Structure
REQ-030 SHALL take the state enum piso_state_e and the parity-beat lane constant from shared package piso_pkg.
REQ-031 SHALL place beat counting (load, decrement, last-flag) in sub-module piso_beat_counter; the shift datapath and FSM stay in the top level.

Verification
REQ-032 SHALL cover: DATA_WIDTH=16, LANES=1, MSB_FIRST=0, din=16'hA5C3, dout_ready=1 -> beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, dout_last on beat 16.
REQ-033 SHALL cover: LANES=4, MSB_FIRST=1, din=16'h1234 -> beats 1,2,3,4 with dout_last on beat 4; MSB_FIRST=0 -> beats 4,3,2,1.
REQ-034 SHALL cover: din_valid held 1 with words 16'h0001 and 16'h8000, LANES=8 -> 4 consecutive valid beats 01,00,00,80 with no idle cycle between words.
REQ-035 SHALL cover: dout_ready=0 for 5 cycles mid-word -> dout, dout_last and dout_valid unchanged and din_ready=0 throughout.
REQ-036 SHALL cover: reset pulsed during beat 3 of 16'hFFFF -> dout_valid=0 immediately, din_ready=1 after release, next word 16'h0000 emits all-zero beats.
REQ-037 SHALL cover: PISO_PARITY_EN with din=16'h0007, LANES=4 -> 5 beats 7,0,0,0,1, dout_last on beat 5 only.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO stream serializer.
// PISO_PARITY_EN adds the PARITY state to the state enum.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } piso_state_e;

  localparam int unsigned PARITY_LANE = 0;

endpackage

// File: rtl/piso_beat_counter.sv
// Down-counter of beats remaining in the current word.
// load_i presets it to BEATS-1 and dec_i counts down. last_o flags the final data beat.
module piso_beat_counter #(
  parameter int BEATS = 16,
  localparam int CW = $clog2(BEATS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = CW'(BEATS - 1);
    else if (dec_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in serial-out serializer with valid/ready handshakes on both sides.
// Defining PISO_PARITY_EN appends an even-parity beat after each word.
module piso_stream_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [LANES-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / LANES;

  if (DATA_WIDTH % LANES != 0) begin : g_bad_lanes
    $error("piso_stream_serializer: DATA_WIDTH must be a multiple of LANES");
  end

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  rdy_en_q;
  logic                  accept;
  logic                  cnt_load, cnt_dec, cnt_last;
  logic [LANES-1:0]      beat_data;
  logic [DATA_WIDTH-1:0] sreg_shift;
`ifdef PISO_PARITY_EN
  logic                  par_q;
`endif

  assign beat_data  = (MSB_FIRST != 0) ? sreg_q[DATA_WIDTH-1 -: LANES] : sreg_q[LANES-1:0];
  assign sreg_shift = (MSB_FIRST != 0) ? (sreg_q << LANES) : (sreg_q >> LANES);

  piso_beat_counter #(.BEATS(BEATS)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    din_ready  = 1'b0;
    dout       = '0;
    case (state_q)
      ST_IDLE: din_ready = rdy_en_q;
      ST_SHIFT: begin
        dout_valid = 1'b1;
        dout       = beat_data;
`ifndef PISO_PARITY_EN
        dout_last  = cnt_last;
        din_ready  = cnt_last & dout_ready;
`endif
        if (dout_ready) begin
          if (!cnt_last) begin
            cnt_dec = 1'b1;
            sreg_d  = sreg_shift;
          end else begin
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        dout_valid        = 1'b1;
        dout_last         = 1'b1;
        dout[PARITY_LANE] = par_q;
        din_ready         = dout_ready;
        if (dout_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // A word taken on the last-beat handshake overrides the return to IDLE
    accept = din_valid & din_ready;
    if (accept) begin
      state_d  = ST_SHIFT;
      sreg_d   = din;
      cnt_load = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       par_q <= 1'b0;
    else if (accept) par_q <= ^din;
  end
`endif

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Directed bench for piso_stream_serializer over four lane/order configurations.
// Honours PISO_PARITY_EN by expecting the appended parity beat.
module tb_piso_stream_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        dout_ready = 1'b1;

  logic [0:0] dout_a;  logic val_a, last_a, rdy_a, busy_a;
  logic [3:0] dout_b;  logic val_b, last_b, rdy_b, busy_b;
  logic [3:0] dout_c;  logic val_c, last_c, rdy_c, busy_c;
  logic [7:0] dout_d;  logic val_d, last_d, rdy_d, busy_d;

  int          sel = 0;
  logic [7:0]  c_dout;
  logic        c_valid, c_last, c_ready, c_busy;
  int          n_tot = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
    .dout(dout_a), .dout_valid(val_a), .dout_ready(dout_ready), .dout_last(last_a), .busy(busy_a));
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
    .dout(dout_b), .dout_valid(val_b), .dout_ready(dout_ready), .dout_last(last_b), .busy(busy_b));
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_c (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_c),
    .dout(dout_c), .dout_valid(val_c), .dout_ready(dout_ready), .dout_last(last_c), .busy(busy_c));
  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(8), .MSB_FIRST(0)) u_d (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_d),
    .dout(dout_d), .dout_valid(val_d), .dout_ready(dout_ready), .dout_last(last_d), .busy(busy_d));

  always_comb begin
    c_dout = '0; c_valid = 1'b0; c_last = 1'b0; c_ready = 1'b0; c_busy = 1'b0;
    case (sel)
      0: begin c_dout = {7'd0, dout_a}; c_valid = val_a; c_last = last_a; c_ready = rdy_a; c_busy = busy_a; end
      1: begin c_dout = {4'd0, dout_b}; c_valid = val_b; c_last = last_b; c_ready = rdy_b; c_busy = busy_b; end
      2: begin c_dout = {4'd0, dout_c}; c_valid = val_c; c_last = last_c; c_ready = rdy_c; c_busy = busy_c; end
      default: begin c_dout = dout_d; c_valid = val_d; c_last = last_d; c_ready = rdy_d; c_busy = busy_d; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; din_valid = 1'b0; dout_ready = 1'b1; din = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk({tag, ".rst_valid"}, c_valid, 0);
    chk({tag, ".rst_ready"}, c_ready, 0);
    chk({tag, ".rst_busy"},  c_busy, 0);
    chk({tag, ".rst_dout"},  c_dout, 0);
    chk({tag, ".rst_last"},  c_last, 0);
    reset = 1'b0;
    #1 chk({tag, ".rdy_pre_edge"}, c_ready, 0);
    @(negedge clk);
    #1 chk({tag, ".rdy_post_edge"}, c_ready, 1);
  endtask

  // Sends one word and checks every beat in exp_q; stall_at >= 0 holds dout_ready low for 5 cycles there.
  task automatic do_word(input logic [15:0] w, input int stall_at, input string tag);
`ifdef PISO_PARITY_EN
    exp_q.push_back({7'd0, ^w});
`endif
    @(negedge clk);
    din = w; din_valid = 1'b1; dout_ready = 1'b1;
    #1 chk({tag, ".accept_rdy"}, c_ready, 1);
    @(negedge clk);
    din_valid = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == stall_at) begin
        dout_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk($sformatf("%s.stall%0d_dout", tag, s),  c_dout, exp_q[k]);
          chk($sformatf("%s.stall%0d_valid", tag, s), c_valid, 1);
          chk($sformatf("%s.stall%0d_last", tag, s),  c_last, (k == exp_q.size() - 1));
          chk($sformatf("%s.stall%0d_rdy", tag, s),   c_ready, 0);
          @(negedge clk);
        end
        dout_ready = 1'b1;
      end
      #1;
      chk($sformatf("%s.b%0d_dout", tag, k),  c_dout, exp_q[k]);
      chk($sformatf("%s.b%0d_valid", tag, k), c_valid, 1);
      chk($sformatf("%s.b%0d_last", tag, k),  c_last, (k == exp_q.size() - 1));
      @(negedge clk);
    end
    #1;
    chk({tag, ".end_valid"}, c_valid, 0);
    chk({tag, ".end_busy"},  c_busy, 0);
    chk({tag, ".end_dout"},  c_dout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // LANES=1, LSB first
    sel = 0;
    do_reset("l1");
    exp_q = {8'h1, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h1,
             8'h1, 8'h0, 8'h1, 8'h0, 8'h0, 8'h1, 8'h0, 8'h1};
    do_word(16'hA5C3, -1, "l1_a5c3");

    // LANES=4, MSB first and LSB first
    sel = 1;
    do_reset("l4m");
    exp_q = {8'h1, 8'h2, 8'h3, 8'h4};
    do_word(16'h1234, -1, "l4m_1234");
    sel = 2;
    do_reset("l4l");
    exp_q = {8'h4, 8'h3, 8'h2, 8'h1};
    do_word(16'h1234, -1, "l4l_1234");

`ifndef PISO_PARITY_EN
    // LANES=8, back-to-back words with no bubble
    sel = 3;
    do_reset("b2b");
    @(negedge clk);
    din = 16'h0001; din_valid = 1'b1; dout_ready = 1'b1;
    #1 chk("b2b.acc_rdy", c_ready, 1);
    @(negedge clk);
    din = 16'h8000;
    #1;
    chk("b2b.b0_dout", c_dout, 8'h01); chk("b2b.b0_valid", c_valid, 1);
    chk("b2b.b0_last", c_last, 0);     chk("b2b.b0_rdy", c_ready, 0);
    @(negedge clk);
    #1;
    chk("b2b.b1_dout", c_dout, 8'h00); chk("b2b.b1_valid", c_valid, 1);
    chk("b2b.b1_last", c_last, 1);     chk("b2b.b1_rdy", c_ready, 1);
    @(negedge clk);
    #1;
    chk("b2b.b2_dout", c_dout, 8'h00); chk("b2b.b2_valid", c_valid, 1);
    chk("b2b.b2_last", c_last, 0);
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    chk("b2b.b3_dout", c_dout, 8'h80); chk("b2b.b3_valid", c_valid, 1);
    chk("b2b.b3_last", c_last, 1);
    @(negedge clk);
    #1 chk("b2b.end_valid", c_valid, 0);
`endif

    // Back-pressure on beat 2 of 16'h0004 (held beat is 1)
    sel = 0;
    do_reset("bp");
    exp_q = {8'h0, 8'h0, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0,
             8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    do_word(16'h0004, 2, "bp_0004");

    // Reset during beat 3 of 16'hFFFF, then a clean all-zero word
    do_reset("mid");
    @(negedge clk);
    din = 16'hFFFF; din_valid = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("mid.b%0d_dout", k), c_dout, 1);
      @(negedge clk);
    end
    #1;
    chk("mid.b2_valid", c_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid.rst_valid", c_valid, 0);
    chk("mid.rst_dout",  c_dout, 0);
    chk("mid.rst_busy",  c_busy, 0);
    chk("mid.rst_rdy",   c_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mid.rdy_pre_edge", c_ready, 0);
    @(negedge clk);
    #1 chk("mid.rdy_post_edge", c_ready, 1);
    exp_q = {};
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h0);
    do_word(16'h0000, -1, "mid_zero");

    // LANES=4 LSB first on 16'h0007 (parity beat 1 appended when enabled)
    sel = 2;
    do_reset("par");
    exp_q = {8'h7, 8'h0, 8'h0, 8'h0};
    do_word(16'h0007, -1, "par_0007");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
